// File: rtl/cmult_acc_dump.sv
// Complex accumulate-and-dump: sums ACC_LEN valid products, rounds by SHIFT,
// saturates to OUT_WIDTH and strobes one result per block.
module cmult_acc_dump #(
  parameter int IN_WIDTH  = 35,
  parameter int ACC_LEN   = 16,
  parameter int SHIFT     = 4,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [IN_WIDTH-1:0]  pr_i,
  input  logic signed [IN_WIDTH-1:0]  pi_i,
  input  logic                        valid_i,
  input  logic                        clear_i,
  output logic signed [OUT_WIDTH-1:0] yr_o,
  output logic signed [OUT_WIDTH-1:0] yi_o,
  output logic                        valid_o,
  output logic                        ovf_o
);

  localparam int ACC_WIDTH = IN_WIDTH + $clog2(ACC_LEN);
  localparam int EXT_W     = ACC_WIDTH + 1;
  localparam int CNT_W     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  localparam logic [CNT_W-1:0]        LAST     = CNT_W'(ACC_LEN - 1);
  localparam logic [EXT_W-1:0]        ONE      = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] HALF     = (ONE << SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX  = (ONE << (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [EXT_W-1:0] SAT_MIN  = -(ONE << (OUT_WIDTH - 1));

  logic [CNT_W-1:0]            cnt_q, cnt_d, baseCnt;
  logic signed [ACC_WIDTH-1:0] accR_q, accR_d, accI_q, accI_d;
  logic signed [ACC_WIDTH-1:0] dumpR_q, dumpR_d, dumpI_q, dumpI_d;
  logic signed [ACC_WIDTH-1:0] sumR, sumI;
  logic                        dumpVld_q, dumpVld_d;
  logic signed [EXT_W-1:0]     biasR, biasI;
  logic signed [EXT_W-1:0]     rndR_q, rndR_d, rndI_q, rndI_d;
  logic                        rndVld_q;
  logic signed [OUT_WIDTH-1:0] yr_q, yr_d, yi_q, yi_d;
  logic                        ovf_q, ovf_d, valid_q;

  // A clear makes the current sample (if any) the first of a fresh block.
  always_comb begin
    cnt_d     = cnt_q;
    accR_d    = accR_q;
    accI_d    = accI_q;
    dumpR_d   = dumpR_q;
    dumpI_d   = dumpI_q;
    dumpVld_d = 1'b0;
    baseCnt   = clear_i ? '0 : cnt_q;
    sumR      = accR_q + ACC_WIDTH'(pr_i);
    sumI      = accI_q + ACC_WIDTH'(pi_i);
    if (baseCnt == '0) begin
      sumR = ACC_WIDTH'(pr_i);
      sumI = ACC_WIDTH'(pi_i);
    end
    if (clear_i) cnt_d = '0;
    if (valid_i) begin
      if (baseCnt == LAST) begin
        dumpR_d   = sumR;
        dumpI_d   = sumI;
        dumpVld_d = 1'b1;
        cnt_d     = '0;
      end else begin
        accR_d = sumR;
        accI_d = sumI;
        cnt_d  = baseCnt + 1'b1;
      end
    end
  end

  // Round half toward +inf: bias then arithmetic shift; one guard bit absorbs the bias.
  always_comb begin
    biasR  = EXT_W'(dumpR_q) + HALF;
    biasI  = EXT_W'(dumpI_q) + HALF;
    rndR_d = rndR_q;
    rndI_d = rndI_q;
    if (dumpVld_q) begin
      rndR_d = biasR >>> SHIFT;
      rndI_d = biasI >>> SHIFT;
    end
  end

  always_comb begin
    yr_d  = yr_q;
    yi_d  = yi_q;
    ovf_d = ovf_q;
    if (rndVld_q) begin
      ovf_d = 1'b0;
      if (rndR_q > SAT_MAX) begin
        yr_d  = OUT_WIDTH'(SAT_MAX);
        ovf_d = 1'b1;
      end else if (rndR_q < SAT_MIN) begin
        yr_d  = OUT_WIDTH'(SAT_MIN);
        ovf_d = 1'b1;
      end else begin
        yr_d = OUT_WIDTH'(rndR_q);
      end
      if (rndI_q > SAT_MAX) begin
        yi_d  = OUT_WIDTH'(SAT_MAX);
        ovf_d = 1'b1;
      end else if (rndI_q < SAT_MIN) begin
        yi_d  = OUT_WIDTH'(SAT_MIN);
        ovf_d = 1'b1;
      end else begin
        yi_d = OUT_WIDTH'(rndI_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      accR_q    <= '0;
      accI_q    <= '0;
      dumpR_q   <= '0;
      dumpI_q   <= '0;
      dumpVld_q <= 1'b0;
      rndR_q    <= '0;
      rndI_q    <= '0;
      rndVld_q  <= 1'b0;
      yr_q      <= '0;
      yi_q      <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      accR_q    <= accR_d;
      accI_q    <= accI_d;
      dumpR_q   <= dumpR_d;
      dumpI_q   <= dumpI_d;
      dumpVld_q <= dumpVld_d;
      rndR_q    <= rndR_d;
      rndI_q    <= rndI_d;
      rndVld_q  <= dumpVld_q;
      yr_q      <= yr_d;
      yi_q      <= yi_d;
      ovf_q     <= ovf_d;
      valid_q   <= rndVld_q;
    end
  end

  assign yr_o    = yr_q;
  assign yi_o    = yi_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_cmult_acc_dump.sv
// Directed bench for cmult_acc_dump with IN_WIDTH=35, ACC_LEN=4, SHIFT=4, OUT_WIDTH=16.
module tb_cmult_acc_dump;

  localparam int IW = 35;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [IW-1:0] pr = '0;
  logic signed [IW-1:0] pi = '0;
  logic                 valid = 1'b0;
  logic                 clr = 1'b0;
  logic signed [OW-1:0] yr, yi;
  logic                 validO, ovf;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;

  typedef struct {
    string  name;
    longint prBase;
    longint prStep;
    longint piBase;
    longint piStep;
    int     expYr;
    int     expYi;
    bit     expOvf;
  } vec_t;

  vec_t vecs[8];

  cmult_acc_dump #(.IN_WIDTH(IW), .ACC_LEN(4), .SHIFT(4), .OUT_WIDTH(OW)) dut (
    .clk_i(clk), .rst_i(rst), .pr_i(pr), .pi_i(pi), .valid_i(valid),
    .clear_i(clr), .yr_o(yr), .yi_o(yi), .valid_o(validO), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (validO) pulseCount++;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input longint r, input longint i, input bit v, input bit c);
    @(negedge clk);
    pr    = IW'(r);
    pi    = IW'(i);
    valid = v;
    clr   = c;
  endtask

  // Called right after the last sample of a block has been driven.
  task automatic checkOutput(input string name, input int expYr, input int expYi, input bit expOvf);
    int lat = 0;
    int highs = 0;
    longint capYr = 0, capYi = 0, capOvf = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        valid = 1'b0;
        clr   = 1'b0;
      end
      if (validO) begin
        highs++;
        if (lat == 0) begin
          lat    = i;
          capYr  = yr;
          capYi  = yi;
          capOvf = ovf;
        end
      end
    end
    check({name, ".latency"}, lat, 3);
    check({name, ".pulses"}, highs, 1);
    check({name, ".yr"}, capYr, expYr);
    check({name, ".yi"}, capYi, expYi);
    check({name, ".ovf"}, capOvf, expOvf);
    check({name, ".holdYr"}, yr, expYr);
  endtask

  initial begin
    int base;
    vecs[0] = '{"basic",    16, 16, -16, -16, 10, -10, 1'b0};
    vecs[1] = '{"tie24",     6,  0,  -6,   0,  2,  -1, 1'b0};
    vecs[2] = '{"tie8",      2,  0,  -2,   0,  1,   0, 1'b0};
    vecs[3] = '{"satPos",  1 << 20, 0, 0, 0, 32767, 0, 1'b1};
    vecs[4] = '{"satNeg",  0, 0, -(1 << 20), 0, 0, -32768, 1'b1};
    vecs[5] = '{"inRange", 100000, 0, -100000, 0, 25000, -25000, 1'b0};
    vecs[6] = '{"edgeExact", 131068, 0, -131072, 0, 32767, -32768, 1'b0};
    vecs[7] = '{"edgeOver",  131072, 0, -131076, 0, 32767, -32768, 1'b1};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.yr", yr, 0);
    check("reset.yi", yi, 0);
    check("reset.valid", validO, 0);
    check("reset.ovf", ovf, 0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      for (int j = 0; j < 4; j++)
        applyStimulus(vecs[v].prBase + vecs[v].prStep * j,
                      vecs[v].piBase + vecs[v].piStep * j, 1'b1, 1'b0);
      checkOutput(vecs[v].name, vecs[v].expYr, vecs[v].expYi, vecs[v].expOvf);
    end

    // Idle gaps between samples must not disturb the partial sum.
    for (int j = 0; j < 4; j++) begin
      applyStimulus(16 * (j + 1), -16 * (j + 1), 1'b1, 1'b0);
      if (j < 3) repeat (2) applyStimulus(0, 0, 1'b0, 1'b0);
    end
    checkOutput("gaps", 10, -10, 1'b0);

    // Clear with a same-cycle sample abandons the first two samples.
    #1 base = pulseCount;
    applyStimulus(16, 0, 1'b1, 1'b0);
    applyStimulus(16, 0, 1'b1, 1'b0);
    applyStimulus(16, 0, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) applyStimulus(16, 0, 1'b1, 1'b0);
    checkOutput("clear", 4, 0, 1'b0);
    #1 check("clear.totalPulses", pulseCount - base, 1);

    // Async reset between edges clears saturated, non-zero outputs at once.
    for (int j = 0; j < 4; j++) applyStimulus(1 << 20, -(1 << 20), 1'b1, 1'b0);
    checkOutput("preReset", 32767, -32768, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("asyncReset.yr", yr, 0);
    check("asyncReset.yi", yi, 0);
    check("asyncReset.ovf", ovf, 0);
    check("asyncReset.valid", validO, 0);
    @(negedge clk) rst = 1'b0;
    #1 base = pulseCount;
    repeat (10) @(negedge clk);
    #1 check("idleAfterReset.pulses", pulseCount - base, 0);

    // Reset while a dump is in the round stage discards it.
    #1 base = pulseCount;
    for (int j = 0; j < 4; j++) applyStimulus(16, 0, 1'b1, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    #1 check("midPipeReset.pulses", pulseCount - base, 0);

    // Continuous stream: strobe every 4 cycles, then reset after sample 14.
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      check($sformatf("stream.valid%0d", j), validO, (j == 7 || j == 11 || j == 15));
      if (j == 7 || j == 11 || j == 15) check($sformatf("stream.yr%0d", j), yr, 4);
      if (j <= 14) begin
        pr    = 16;
        pi    = 0;
        valid = 1'b1;
      end else begin
        valid = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk) rst = 1'b0;
    #1 base = pulseCount;
    repeat (10) @(negedge clk);
    #1 check("streamReset.pulses", pulseCount - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
